// File: rtl/load_writeback_unit.sv
// Load path from the memory stage to the register-file write port: a single AHB-Lite read,
// byte/halfword/word lane extraction with sign/zero extension, and a one-cycle write-back.
module load_writeback_unit #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [4:0]  req_rd,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        busy,
    output logic        load_err,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready; req_ready is
    // high only in IDLE, so a request held during a load is taken on the return to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [4:0]  rd_q;
    logic [31:0] haddr_q;
    logic [1:0]  htrans_q;
    logic [2:0]  hsize_q;
    logic        regwrite_q;
    logic [4:0]  wreg_q;
    logic [31:0] wdata_q;
    logic        load_err_q;

    logic        req_bad;
    logic [1:0]  lane;
    logic        half_hi;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result_d;

    always_comb begin
        case (req_size)
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = |req_addr[1:0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Big-endian mirrors the lanes: 3 - addr[1:0] is the bitwise inverse for two bits.
    always_comb begin
        lane    = BIG_ENDIAN ? ~addr_lo_q : addr_lo_q;
        half_hi = BIG_ENDIAN ? ~addr_lo_q[1] : addr_lo_q[1];
        case (lane)
            2'd0:    byte_v = HRDATA[7:0];
            2'd1:    byte_v = HRDATA[15:8];
            2'd2:    byte_v = HRDATA[23:16];
            default: byte_v = HRDATA[31:24];
        endcase
        half_v = half_hi ? HRDATA[31:16] : HRDATA[15:0];
        case (size_q)
            2'b00:   result_d = {{24{signed_q & byte_v[7]}}, byte_v};
            2'b01:   result_d = {{16{signed_q & half_v[15]}}, half_v};
            default: result_d = HRDATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_lo_q  <= 2'b00;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            rd_q       <= 5'd0;
            haddr_q    <= 32'd0;
            htrans_q   <= 2'b00;
            hsize_q    <= 3'd0;
            regwrite_q <= 1'b0;
            wreg_q     <= 5'd0;
            wdata_q    <= 32'd0;
            load_err_q <= 1'b0;
        end else begin
            regwrite_q <= 1'b0;
            load_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_lo_q <= req_addr[1:0];
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        rd_q      <= req_rd;
                        if (req_bad) begin
                            load_err_q <= 1'b1;
                        end else begin
                            haddr_q  <= req_addr;
                            hsize_q  <= {1'b0, req_size};
                            htrans_q <= 2'b10;
                            state_q  <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        htrans_q <= 2'b00;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            load_err_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            wdata_q    <= result_d;
                            wreg_q     <= rd_q;
                            regwrite_q <= (rd_q != 5'd0);
                            state_q    <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;
    assign HADDR         = haddr_q;
    assign HTRANS        = htrans_q;
    assign HSIZE         = hsize_q;
    assign HWRITE        = 1'b0;
    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign load_err      = load_err_q;

endmodule
